// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, picks the next fetch address (exception > branch > PC+4),
// runs a single-outstanding imem handshake and fills the IF/ID register under ID stalls.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        epc_ctrl,
  input  logic [31:0] jumpAddressExcept,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_jumpOrBranchPc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_4;

  logic        w_accept;
  logic        w_flush;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_accept   = !r_if_valid || !stall;
  assign w_flush    = epc_ctrl || (id_shouldJumpOrBranch && !stall);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = epc_ctrl              ? jumpAddressExcept :
                      id_shouldJumpOrBranch ? id_jumpOrBranchPc : w_pc_plus4;

  // Handshake: a request is live whenever imem_req=1; it completes in the cycle
  // imem_ready=1, and until then imem_addr is frozen at r_addr.
  assign imem_req    = !rst && (r_state != S_HOLD);
  assign imem_addr   = r_addr;
  assign pc          = r_pc;
  assign if_valid    = r_if_valid;
  assign if_inst     = r_if_inst;
  assign if_pc       = r_if_pc;
  assign if_pc_4     = r_if_pc_4;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_buf_inst <= 32'd0;
      r_buf_pc   <= 32'd0;
      r_if_valid <= 1'b0;
      r_if_inst  <= 32'd0;
      r_if_pc    <= 32'd0;
      r_if_pc_4  <= 32'd0;
    end else begin
      // Default IF/ID behaviour; a load below overrides the valid bit.
      if (w_flush || !stall) begin
        r_if_valid <= 1'b0;
      end

      case (r_state)
        S_FETCH: begin
          if (w_flush) begin
            r_pc <= w_target;
            if (imem_ready) begin
              r_addr <= w_target;
            end else begin
              r_state <= S_DISCARD;
            end
          end else if (imem_ready) begin
            r_pc   <= w_pc_plus4;
            r_addr <= w_pc_plus4;
            if (w_accept) begin
              r_if_valid <= 1'b1;
              r_if_inst  <= imem_rdata;
              r_if_pc    <= r_addr;
              r_if_pc_4  <= r_addr + 32'd4;
            end else begin
              r_buf_inst <= imem_rdata;
              r_buf_pc   <= r_addr;
              r_state    <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (w_flush) begin
            r_pc    <= w_target;
            r_addr  <= w_target;
            r_state <= S_FETCH;
          end else if (w_accept) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= r_buf_inst;
            r_if_pc    <= r_buf_pc;
            r_if_pc_4  <= r_buf_pc + 32'd4;
            r_state    <= S_FETCH;
          end
        end

        S_DISCARD: begin
          // The wrong-path word is dropped; the newest redirect target is fetched next.
          if (w_flush) begin
            r_pc <= w_target;
          end
          if (imem_ready) begin
            r_addr  <= w_flush ? w_target : r_pc;
            r_state <= S_FETCH;
          end
        end

        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
